implication_stack: RTL and testbench

Downstream of the conflict detector in the SAT solver datapath. Captures each non-conflicting implication `(var_idx, val)` pushed by the detector into a LIFO, where the solver's propagation controller pops them one at a time for unit propagation.

- Filters duplicate implications of the same variable since the last clear.
- Reports full, empty, overflow and underflow status.
- Is flushed by the solver on conflict or backtrack.

---
 rtl/sysdefs.sv | 17 +
 rtl/seen_bitmap.sv | 17 +
 rtl/implication_stack.sv | 66 ++++++
 tb/tb_implication_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sysdefs.sv
// sysdefs: solver-wide sizing macros and the implication record shared by the
// conflict detector and the implication stack.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif
package sysdefs;
  localparam int MAX_VARS = `MAX_VARS;
  localparam int VAR_W = `MAX_VARS_BITS;
  typedef logic [VAR_W-1:0] var_idx_t;
  typedef struct packed {
    var_idx_t var_idx;
    logic val;
  } implication_t;
endpackage

// File: rtl/seen_bitmap.sv
// seen_bitmap: one bit per variable, marking variables already implied since the last flush.
module seen_bitmap #(
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             set,
  input  logic [IDX_W-1:0] idx,
  output logic             hit
);
  logic [(2**IDX_W)-1:0] bits;
  assign hit = bits[idx];
  always_ff @(posedge clock)
    if (reset || clear) bits <= '0;
    else if (set) bits[idx] <= 1'b1;
endmodule

// File: rtl/implication_stack.sv
// implication_stack: LIFO of unique implications feeding unit propagation,
// with duplicate filtering, occupancy status and flush on conflict/backtrack.
module implication_stack
  import sysdefs::*;
#(
  parameter int DEPTH = `MAX_VARS,
  parameter int IDX_W = `MAX_VARS_BITS,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_en,
  input  logic [IDX_W-1:0] push_var_idx,
  input  logic             push_val,
  input  logic             pop_en,
  input  logic             clear,
  output logic [IDX_W-1:0] top_var_idx,
  output logic             top_val,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             dup_drop,
  output logic             underflow,
  output logic             overflow
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  implication_t entry [DEPTH];
  logic [CNT_W-1:0] sp;
  logic [PTR_W-1:0] top_ptr, wr_ptr;
  logic hit, do_pop, fits, push_ok, drop_full;
  seen_bitmap #(.IDX_W(IDX_W)) u_seen (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .set(push_ok && !clear),
    .idx(push_var_idx),
    .hit(hit)
  );
  assign count = sp;
  assign empty = sp == '0;
  assign full = sp == CNT_W'(DEPTH);
  assign do_pop = pop_en && !empty;
  // the pop frees a slot before the push is judged, so push+pop while full fits
  assign fits = !full || do_pop;
  assign push_ok = push_en && !hit && fits;
  assign drop_full = push_en && !hit && !fits;
  assign top_ptr = PTR_W'(sp - CNT_W'(1));
  assign wr_ptr = do_pop ? top_ptr : PTR_W'(sp);
  assign top_var_idx = empty ? '0 : IDX_W'(entry[top_ptr].var_idx);
  assign top_val = empty ? 1'b0 : entry[top_ptr].val;
  always_ff @(posedge clock)
    if (push_ok && !clear && !reset)
      entry[wr_ptr] <= '{var_idx: var_idx_t'(push_var_idx), val: push_val};
  always_ff @(posedge clock)
    if (reset || clear) begin
      sp <= '0;
      overflow <= 1'b0;
      dup_drop <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp - CNT_W'(do_pop) + CNT_W'(push_ok);
      overflow <= overflow || drop_full;
      dup_drop <= push_en && hit;
      underflow <= pop_en && empty;
    end
endmodule

// File: tb/tb_implication_stack.sv
// tb_implication_stack: scenario tasks against a LIFO queue scoreboard and seen model.
module tb_implication_stack;
  localparam int D = 4;
  localparam int W = 4;
  localparam int C = 3;
  logic clock = 1'b0;
  logic reset = 1'b0, push_en = 1'b0, push_val = 1'b0, pop_en = 1'b0, clear = 1'b0;
  logic [W-1:0] push_var_idx = '0;
  logic [W-1:0] top_var_idx;
  logic top_val, empty, full, dup_drop, underflow, overflow;
  logic [C-1:0] count;
  typedef struct packed {
    logic [W-1:0] idx;
    logic val;
  } ent_t;
  ent_t q[$];
  bit seen_m[16];
  bit ov_m, dup_m, uf_m;
  int checks = 0, errors = 0;
  implication_stack #(.DEPTH(D), .IDX_W(W), .CNT_W(C)) dut (
    .clock(clock), .reset(reset), .push_en(push_en), .push_var_idx(push_var_idx),
    .push_val(push_val), .pop_en(pop_en), .clear(clear), .top_var_idx(top_var_idx),
    .top_val(top_val), .empty(empty), .full(full), .count(count),
    .dup_drop(dup_drop), .underflow(underflow), .overflow(overflow)
  );
  always #5 clock = ~clock;
  task automatic step(input bit pe, input logic [W-1:0] idx, input bit v, input bit po, input bit cl);
    bit dp, ht, ft;
    if (cl) begin
      q.delete();
      foreach (seen_m[i]) seen_m[i] = 1'b0;
      ov_m = 1'b0; dup_m = 1'b0; uf_m = 1'b0;
    end else begin
      dp = po && q.size() > 0;
      ht = seen_m[idx];
      ft = q.size() < D || dp;
      dup_m = pe && ht;
      uf_m = po && q.size() == 0;
      if (pe && !ht && !ft) ov_m = 1'b1;
      if (dp) void'(q.pop_back());
      if (pe && !ht && ft) begin
        q.push_back('{idx: idx, val: v});
        seen_m[idx] = 1'b1;
      end
    end
    push_en = pe; push_var_idx = idx; push_val = v; pop_en = po; clear = cl;
    @(posedge clock); #1;
    push_en = 1'b0; pop_en = 1'b0; clear = 1'b0;
  endtask
  task automatic do_reset(input bit pe, input logic [W-1:0] idx);
    reset = 1'b1; push_en = pe; push_var_idx = idx; push_val = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; push_en = 1'b0;
    q.delete();
    foreach (seen_m[i]) seen_m[i] = 1'b0;
    ov_m = 1'b0; dup_m = 1'b0; uf_m = 1'b0;
  endtask
  task automatic test_reset;
    do_reset(1'b1, 4'd3);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
    checks++; if (top_var_idx !== 4'd0 || top_val !== 1'b0) begin errors++; $display("FAIL reset_top got %0d,%b want 0,0", top_var_idx, top_val); end
    checks++; if ({dup_drop, underflow, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {dup_drop, underflow, overflow}); end
  endtask
  task automatic test_lifo;
    ent_t e;
    step(1, 5, 1, 0, 0); step(1, 9, 0, 0, 0); step(1, 2, 1, 0, 0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL lifo_count got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      e = q[$];
      checks++; if (top_var_idx !== e.idx || top_val !== e.val) begin errors++; $display("FAIL lifo_pop%0d got %0d,%b want %0d,%b", i, top_var_idx, top_val, e.idx, e.val); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL lifo_empty got empty=%b count=%0d want 1 0", empty, count); end
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_dup;
    step(1, 7, 1, 0, 0); step(1, 7, 0, 0, 0);
    checks++; if (dup_drop !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL dup_drop got dup=%b count=%0d want 1 1", dup_drop, count); end
    checks++; if (top_var_idx !== 4'd7 || top_val !== 1'b1) begin errors++; $display("FAIL dup_top got %0d,%b want 7,1", top_var_idx, top_val); end
    step(0, 0, 0, 0, 0);
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_pulse_len got %b want 0", dup_drop); end
    step(0, 0, 0, 1, 0); step(1, 7, 1, 0, 0);
    checks++; if (dup_drop !== dup_m || count !== C'(q.size())) begin errors++; $display("FAIL dup_after_pop got dup=%b count=%0d want %b %0d", dup_drop, count, dup_m, q.size()); end
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_overflow;
    for (int i = 1; i <= 4; i++) step(1, W'(i), 1'(i), 0, 0);
    step(1, 5, 1, 0, 0);
    checks++; if (full !== 1'b1 || overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_status got full=%b ovf=%b count=%0d want 1 1 4", full, overflow, count); end
    checks++; if (top_var_idx !== 4'd4 || top_val !== 1'b0) begin errors++; $display("FAIL ovf_top got %0d,%b want 4,0", top_var_idx, top_val); end
    step(1, 6, 0, 1, 0);
    checks++; if (count !== 3'd4 || top_var_idx !== 4'd6 || top_val !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_pushpop got count=%0d top=%0d,%b ovf=%b want 4 6,0 1", count, top_var_idx, top_val, overflow); end
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_underflow;
    step(0, 0, 0, 1, 0);
    checks++; if (underflow !== 1'b1 || count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL uf_pulse got uf=%b count=%0d empty=%b ovf=%b want 1 0 1 0", underflow, count, empty, overflow); end
    step(0, 0, 0, 0, 0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_pulse_len got %b want 0", underflow); end
  endtask
  task automatic test_clear;
    step(1, 5, 1, 0, 0); step(1, 9, 0, 0, 0); step(1, 2, 1, 0, 0); step(1, 3, 0, 0, 0);
    step(1, 6, 1, 0, 0); step(0, 0, 0, 1, 0);
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL clr_setup got count=%0d ovf=%b want 3 1", count, overflow); end
    step(1, 8, 1, 1, 1);
    checks++; if (count !== 3'd0 || overflow !== 1'b0 || dup_drop !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_state got count=%0d ovf=%b dup=%b uf=%b want 0 0 0 0", count, overflow, dup_drop, underflow); end
    step(1, 5, 0, 0, 0);
    checks++; if (count !== 3'd1 || dup_drop !== 1'b0 || top_var_idx !== 4'd5) begin errors++; $display("FAIL clr_reseen got count=%0d dup=%b top=%0d want 1 0 5", count, dup_drop, top_var_idx); end
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_reset_mid;
    step(1, 11, 1, 0, 0); step(1, 12, 0, 0, 0);
    do_reset(1'b1, 4'd13);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_mid got count=%0d empty=%b want 0 1", count, empty); end
    step(1, 11, 0, 0, 0);
    checks++; if (count !== 3'd1 || dup_drop !== 1'b0 || top_var_idx !== 4'd11) begin errors++; $display("FAIL rst_seen got count=%0d dup=%b top=%0d want 1 0 11", count, dup_drop, top_var_idx); end
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_back_to_back;
    ent_t e;
    for (int n = 0; n < 60; n++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 14) == 0);
      checks++; if (count !== C'(q.size()) || {dup_drop, underflow, overflow} !== {dup_m, uf_m, ov_m}) begin errors++; $display("FAIL b2b_%0d got count=%0d flags=%b want %0d %b", n, count, {dup_drop, underflow, overflow}, q.size(), {dup_m, uf_m, ov_m}); end
      if (q.size() > 0) begin
        e = q[$];
        checks++; if (top_var_idx !== e.idx || top_val !== e.val) begin errors++; $display("FAIL b2b_top_%0d got %0d,%b want %0d,%b", n, top_var_idx, top_val, e.idx, e.val); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_lifo();
    test_dup();
    test_overflow();
    test_underflow();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
